// File: rtl/acia_tx_cfg.sv
// Configurable ACIA transmitter: byte FIFO feeding a UART framer with
// per-frame latched divisor, data length, parity and stop-bit settings.
module acia_tx_cfg #(
  parameter int SCW = 16,
  parameter int FAW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     tx_dat,
  input  logic           tx_we,
  input  logic [SCW-1:0] cfg_div,
  input  logic [1:0]     cfg_bits,
  input  logic [1:0]     cfg_par,
  input  logic           cfg_stop,
  input  logic           tx_break,
  input  logic           ovr_clr,
  output logic           tx_serial,
  output logic           tx_busy,
  output logic           fifo_empty,
  output logic           fifo_full,
  output logic [FAW:0]   fifo_cnt,
  output logic           tx_ovr
);

  localparam int DEPTH = 2**FAW;
  localparam logic [FAW:0] CNT_FULL = (FAW+1)'(DEPTH);
  localparam logic [FAW:0] CNT_ONE  = (FAW+1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [7:0]     r_mem [DEPTH];
  logic [7:0]     r_rd_dat;
  logic [FAW-1:0] r_wptr;
  logic [FAW-1:0] r_rptr;
  logic [FAW:0]   r_cnt;
  logic           r_empty;
  logic           r_full;
  logic           r_ovr;

  state_t         r_state;
  logic [SCW-1:0] r_div;
  logic [SCW-1:0] r_cyc;
  logic [2:0]     r_last_bit;
  logic [2:0]     r_bitn;
  logic           r_par_en;
  logic           r_odd;
  logic           r_stop2;
  logic           r_stopn;
  logic [7:0]     r_shift;
  logic           r_par;
  logic           r_tx;
  logic           r_busy;

  logic           w_wr;
  logic           w_pop;
  logic           w_bit_end;
  logic           w_can_start;
  logic           w_frame_done;
  logic [FAW:0]   w_cnt_next;
  logic           w_line;

  // Full is judged on the pre-edge count, so a same-edge pop never frees room for a write.
  assign w_wr         = tx_we & ~r_full;
  assign w_bit_end    = (r_cyc == r_div);
  assign w_can_start  = ~r_empty & ~tx_break;
  assign w_frame_done = (r_state == ST_STOP) & w_bit_end & (r_stopn == r_stop2);
  assign w_pop        = w_can_start & ((r_state == ST_IDLE) | w_frame_done);

  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_wr, w_pop})
      2'b10:   w_cnt_next = r_cnt + CNT_ONE;
      2'b01:   w_cnt_next = r_cnt - CNT_ONE;
      default: w_cnt_next = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + FAW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FAW'(1);
      end
      r_cnt   <= w_cnt_next;
      r_empty <= (w_cnt_next == '0);
      r_full  <= (w_cnt_next == CNT_FULL);
      if (tx_we && r_full) begin
        r_ovr <= 1'b1;
      end else if (ovr_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  // Storage array with a registered read port; pop never aliases a write slot.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= tx_dat;
    end
    if (w_pop) begin
      r_rd_dat <= r_mem[r_rptr];
    end
  end

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      ST_IDLE:   w_line = ~tx_break;
      ST_START:  w_line = 1'b0;
      ST_DATA:   w_line = r_shift[0];
      ST_PARITY: w_line = r_par ^ r_odd;
      default:   w_line = 1'b1;
    endcase
  end

  // The line and busy registers trail the state by one cycle, so each bit
  // keeps its full cfg_div+1 duration on the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_cyc      <= '0;
      r_last_bit <= '0;
      r_bitn     <= '0;
      r_par_en   <= 1'b0;
      r_odd      <= 1'b0;
      r_stop2    <= 1'b0;
      r_stopn    <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_tx   <= w_line;
      r_busy <= (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          r_cyc <= '0;
        end
        ST_START: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_shift <= r_rd_dat;
            r_state <= ST_DATA;
          end else begin
            r_cyc <= r_cyc + SCW'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            r_par   <= r_par ^ r_shift[0];
            r_bitn  <= r_bitn + 3'd1;
            if (r_bitn == r_last_bit) begin
              r_stopn <= 1'b0;
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
            end
          end else begin
            r_cyc <= r_cyc + SCW'(1);
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_stopn <= 1'b0;
            r_state <= ST_STOP;
          end else begin
            r_cyc <= r_cyc + SCW'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            if (r_stopn == r_stop2) begin
              r_state <= ST_IDLE;
            end else begin
              r_stopn <= 1'b1;
            end
          end else begin
            r_cyc <= r_cyc + SCW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      // A pop starts a frame and snapshots the configuration for its whole duration.
      if (w_pop) begin
        r_div      <= cfg_div;
        r_last_bit <= {1'b1, cfg_bits};
        r_par_en   <= cfg_par[1];
        r_odd      <= cfg_par[0];
        r_stop2    <= cfg_stop;
        r_cyc      <= '0;
        r_bitn     <= '0;
        r_par      <= 1'b0;
        r_state    <= ST_START;
      end
    end
  end

  assign tx_serial  = r_tx;
  assign tx_busy    = r_busy;
  assign fifo_empty = r_empty;
  assign fifo_full  = r_full;
  assign fifo_cnt   = r_cnt;
  assign tx_ovr     = r_ovr;

endmodule

// File: tb/tb_acia_tx_cfg.sv
// Directed bench for acia_tx_cfg: frame shape/timing, FIFO overrun, break and reset.
module tb_acia_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_dat;
  logic        tx_we;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_bits;
  logic [1:0]  cfg_par;
  logic        cfg_stop;
  logic        tx_break;
  logic        ovr_clr;
  logic        tx_serial;
  logic        tx_busy;
  logic        fifo_empty;
  logic        fifo_full;
  logic [4:0]  fifo_cnt;
  logic        tx_ovr;

  int checks = 0;
  int failures = 0;

  acia_tx_cfg #(.SCW(16), .FAW(4)) dut (
    .clk(clk), .rst(rst), .tx_dat(tx_dat), .tx_we(tx_we),
    .cfg_div(cfg_div), .cfg_bits(cfg_bits), .cfg_par(cfg_par), .cfg_stop(cfg_stop),
    .tx_break(tx_break), .ovr_clr(ovr_clr), .tx_serial(tx_serial), .tx_busy(tx_busy),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_cnt(fifo_cnt), .tx_ovr(tx_ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int div, input logic [1:0] bits, input logic [1:0] par, input logic stop);
    cfg_div  = 16'(div);
    cfg_bits = bits;
    cfg_par  = par;
    cfg_stop = stop;
  endtask

  task automatic write_byte(input logic [7:0] d);
    tx_dat = d;
    tx_we  = 1'b1;
    @(negedge clk);
    tx_we  = 1'b0;
    $display("write 0x%02h cnt=%0d", d, fifo_cnt);
  endtask

  // Reference frame: bit i of f is the line level during the i-th bit period.
  task automatic make_frame(input logic [7:0] d, input int nb, input int pmode, input int nstop,
                            output logic [11:0] f, output int n);
    logic p;
    f = '0;
    p = 1'b0;
    n = 1;
    for (int k = 0; k < nb; k++) begin
      f[n] = d[k];
      p = p ^ d[k];
      n++;
    end
    if (pmode >= 2) begin
      f[n] = p ^ (pmode == 3);
      n++;
    end
    for (int k = 0; k < nstop; k++) begin
      f[n] = 1'b1;
      n++;
    end
  endtask

  // Samples every cycle of a frame; act 1 scrambles config, act 2 raises tx_break.
  task automatic check_frame(input logic [11:0] bits, input int n, input int per, input int skip,
                             input int act_at, input int act, input string tag);
    int cyc;
    logic ok;
    logic busy_ok;
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      ok = 1'b1;
      busy_ok = 1'b1;
      for (int c = 0; c < per; c++) begin
        if (cyc >= skip) begin
          @(negedge clk);
          if (tx_serial !== bits[i]) ok = 1'b0;
          if (tx_busy !== 1'b1) busy_ok = 1'b0;
        end
        if (cyc == act_at) begin
          if (act == 1) set_cfg(0, 2'b00, 2'b11, 1'b0);
          if (act == 2) tx_break = 1'b1;
        end
        cyc++;
      end
      chk({31'd0, ok}, 32'd1, $sformatf("%s_bit%0d", tag, i));
      chk({31'd0, busy_ok}, 32'd1, $sformatf("%s_busy%0d", tag, i));
    end
    $display("frame %s checked bits=%0d period=%0d", tag, n, per);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({31'd0, tx_serial}, 32'd1, {tag, "_line"});
    chk({31'd0, tx_busy}, 32'd0, {tag, "_busy"});
  endtask

  initial begin
    logic [11:0] f;
    int n;
    logic ok;

    rst = 1'b1; tx_dat = '0; tx_we = 1'b0; tx_break = 1'b0; ovr_clr = 1'b0;
    set_cfg(138, 2'b11, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    chk({31'd0, tx_serial}, 32'd1, "rst_line");
    chk({31'd0, tx_busy}, 32'd0, "rst_busy");
    chk({31'd0, fifo_empty}, 32'd1, "rst_empty");
    chk({31'd0, fifo_full}, 32'd0, "rst_full");
    chk({27'd0, fifo_cnt}, 32'd0, "rst_cnt");
    chk({31'd0, tx_ovr}, 32'd0, "rst_ovr");
    rst = 1'b0;
    @(negedge clk);

    // 8N1, divisor 138, 0x55
    write_byte(8'h55);
    chk({27'd0, fifo_cnt}, 32'd1, "8n1_cnt_after_wr");
    chk({31'd0, fifo_empty}, 32'd0, "8n1_empty_after_wr");
    @(negedge clk);
    chk({31'd0, tx_serial}, 32'd1, "8n1_line_e1");
    chk({27'd0, fifo_cnt}, 32'd0, "8n1_cnt_after_pop");
    check_frame(12'h2AA, 10, 139, 0, -1, 0, "8n1");
    check_idle("8n1_end");

    // 7E2 and 7O2, 0x41
    set_cfg(3, 2'b10, 2'b10, 1'b1);
    write_byte(8'h41);
    @(negedge clk);
    check_frame(12'h682, 11, 4, 0, -1, 0, "7e2");
    check_idle("7e2_end");
    set_cfg(3, 2'b10, 2'b11, 1'b1);
    write_byte(8'h41);
    @(negedge clk);
    check_frame(12'h782, 11, 4, 0, -1, 0, "7o2");
    check_idle("7o2_end");

    // 5-bit odd, one-cycle bits, 0x1F
    set_cfg(0, 2'b00, 2'b11, 1'b0);
    write_byte(8'h1F);
    @(negedge clk);
    chk({31'd0, tx_serial}, 32'd1, "5o1_line_e1");
    check_frame(12'h0BE, 8, 1, 0, -1, 0, "5o1");
    check_idle("5o1_end");

    // config changed mid-frame must not disturb 8N1 0xA3
    set_cfg(2, 2'b11, 2'b00, 1'b0);
    write_byte(8'hA3);
    @(negedge clk);
    check_frame(12'h346, 10, 3, 0, 5, 1, "cfg_hold");
    check_idle("cfg_hold_end");

    // break raised mid-frame with one byte queued
    set_cfg(2, 2'b11, 2'b00, 1'b0);
    write_byte(8'h3C);
    write_byte(8'hC5);
    make_frame(8'h3C, 8, 0, 1, f, n);
    check_frame(f, n, 3, 0, 7, 2, "brk_a");
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b0 || tx_busy !== 1'b0) ok = 1'b0;
    end
    chk({31'd0, ok}, 32'd1, "brk_line_low");
    chk({27'd0, fifo_cnt}, 32'd1, "brk_held_cnt");
    tx_break = 1'b0;
    @(negedge clk);
    chk({31'd0, tx_serial}, 32'd1, "brk_release_line");
    make_frame(8'hC5, 8, 0, 1, f, n);
    check_frame(f, n, 3, 0, -1, 0, "brk_b");
    check_idle("brk_end");

    // 18 back-to-back writes into a 16-deep FIFO
    set_cfg(138, 2'b11, 2'b00, 1'b0);
    for (int i = 0; i < 18; i++) write_byte(8'(i * 13 + 7));
    chk({31'd0, fifo_full}, 32'd1, "ovf_full");
    chk({27'd0, fifo_cnt}, 32'd16, "ovf_cnt");
    chk({31'd0, tx_ovr}, 32'd1, "ovf_flag");
    tx_dat = 8'hEE; tx_we = 1'b1; ovr_clr = 1'b1;
    @(negedge clk);
    tx_we = 1'b0;
    chk({31'd0, tx_ovr}, 32'd1, "ovr_clr_vs_drop");
    chk({27'd0, fifo_cnt}, 32'd16, "ovf_cnt_hold");
    @(negedge clk);
    ovr_clr = 1'b0;
    chk({31'd0, tx_ovr}, 32'd0, "ovr_cleared");
    for (int i = 0; i < 17; i++) begin
      make_frame(8'(i * 13 + 7), 8, 0, 1, f, n);
      check_frame(f, n, 139, (i == 0) ? 18 : 0, -1, 0, $sformatf("b2b%0d", i));
    end
    check_idle("b2b_end");
    chk({31'd0, fifo_empty}, 32'd1, "b2b_empty");

    // reset in the data phase with three bytes queued
    set_cfg(2, 2'b11, 2'b00, 1'b0);
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({31'd0, tx_serial}, 32'd1, "midrst_line");
    chk({27'd0, fifo_cnt}, 32'd0, "midrst_cnt");
    chk({31'd0, tx_busy}, 32'd0, "midrst_busy");
    chk({31'd0, fifo_empty}, 32'd1, "midrst_empty");
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
    end
    chk({31'd0, ok}, 32'd1, "midrst_quiet");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
